// File: rtl/memory_access_stage_pkg.sv
// Shared types and widths for the memory access stage: access sizes, LSU
// state encoding and the default bus widths.
package memory_access_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int REG_AW     = 5;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/memory_access_stage_align.sv
// Byte-lane steering: store byte enables and replicated data, load extraction
// with sign/zero extension, and the alignment check for a given size/offset.
module mem_align
    import memory_access_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  mem_size_t         size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [BE_W-1:0]   be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    logic [XLEN-1:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            MEM_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{(XLEN-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
            end
            MEM_H: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{(XLEN-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: issues one load/store at a time over a req/gnt/rvalid
// bus, stalls upstream while it is in flight, and registers the WB result.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    input  logic [XLEN-1:0]   alu_y,
    input  logic [XLEN-1:0]   rrd2_fwd,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [REG_AW-1:0] e_rd,
    input  logic              e_regwrite,
    output logic [XLEN-1:0]   m_regwd,
    output logic              mem_stall,
    output logic              misalign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              w_valid,
    output logic [REG_AW-1:0] w_rd,
    output logic              w_regwrite,
    output logic [XLEN-1:0]   w_regwd
);

    lsu_state_t        state, state_nx;
    logic [XLEN-1:0]   r_alu, r_data, r_rdata;
    mem_size_t         r_size;
    logic              r_unsigned, r_we, r_regwrite;
    logic [REG_AW-1:0] r_rd;

    logic              is_idle, memop, start, bad;
    mem_size_t         a_size;
    logic [1:0]        a_lo;
    logic              a_uns, a_misaligned;
    logic [XLEN-1:0]   a_sdata, a_wdata, a_load;
    logic [BE_W-1:0]   a_be;

    // In IDLE the aligner sees the live EX inputs (for the alignment check);
    // afterwards it works from the latched request so the bus stays stable.
    assign is_idle = (state == IDLE);
    assign a_size  = is_idle ? mem_size_t'(mem_size) : r_size;
    assign a_lo    = is_idle ? alu_y[1:0] : r_alu[1:0];
    assign a_uns   = is_idle ? mem_unsigned : r_unsigned;
    assign a_sdata = is_idle ? rrd2_fwd : r_data;

    mem_align #(.XLEN(XLEN)) u_align (
        .size        (a_size),
        .addr_lo     (a_lo),
        .is_unsigned (a_uns),
        .store_data  (a_sdata),
        .rdata       (r_rdata),
        .be          (a_be),
        .wdata       (a_wdata),
        .load_data   (a_load),
        .misaligned  (a_misaligned)
    );

    assign memop = mem_read | mem_write;
    assign start = is_idle & e_valid & memop & ~a_misaligned;
    assign bad   = is_idle & e_valid & memop & a_misaligned;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)       state_nx = REQ;
            REQ:     if (dmem_gnt)    state_nx = WAIT;
            WAIT:    if (dmem_rvalid) state_nx = DONE;
            default:                  state_nx = IDLE;
        endcase
    end

    assign m_regwd    = alu_y;
    assign mem_stall  = (state == REQ) | (state == WAIT) | start;
    assign dmem_req   = (state == REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_alu[ADDR_W-1:2], 2'b00};
    assign dmem_be    = a_be;
    assign dmem_wdata = a_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            misalign   <= 1'b0;
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
            w_rd       <= '0;
            w_regwd    <= '0;
        end else begin
            state    <= state_nx;
            misalign <= bad;
            case (state)
                IDLE: begin
                    w_valid    <= e_valid & ~start;
                    w_rd       <= e_rd;
                    w_regwrite <= e_valid & e_regwrite & ~memop;
                    w_regwd    <= alu_y;
                end
                DONE: begin
                    w_valid    <= 1'b1;
                    w_rd       <= r_rd;
                    w_regwrite <= r_regwrite & ~r_we;
                    w_regwd    <= r_we ? r_alu : a_load;
                end
                default: begin
                    w_valid    <= 1'b0;
                    w_regwrite <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the request/response datapath is not reset; it is only consumed
    // after the FSM has loaded it, so reset would add fan-out for nothing.
    always_ff @(posedge clk) begin
        if (start) begin
            r_alu      <= alu_y;
            r_data     <= rrd2_fwd;
            r_size     <= mem_size_t'(mem_size);
            r_unsigned <= mem_unsigned;
            r_we       <= mem_write & ~mem_read;
            r_rd       <= e_rd;
            r_regwrite <= e_regwrite;
        end
        if (state == WAIT && dmem_rvalid)
            r_rdata <= dmem_rdata;
    end

endmodule
